fetch_unit: RTL and testbench



---
 rtl/cpu_pkg.sv | 20 ++
 rtl/fetch_unit_if.sv | 28 ++
 rtl/next_pc_calc.sv | 31 +++
 rtl/fetch_unit.sv | 78 +++++++
 tb/tb_fetch_unit.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, pc_src encodings and fetch state enum
package cpu_pkg;
  localparam int PC_W        = 16;
  localparam int INSTR_W     = 16;
  localparam int CNT_W       = 16;
  localparam int INSTR_BYTES = 2;

  typedef enum logic [1:0] {
    PCSRC_SEQ  = 2'b00,
    PCSRC_BR   = 2'b01,
    PCSRC_JMP  = 2'b10,
    PCSRC_HOLD = 2'b11
  } pc_src_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    VALID = 2'b10
  } fetch_state_t;
endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - control, instruction-memory and status signals of the fetch stage
interface fetch_unit_if;
  import cpu_pkg::*;

  logic               fetch_req;
  logic [PC_W-1:0]    imem_pc;
  logic [INSTR_W-1:0] imem_instr;
  logic [INSTR_W-1:0] ir;
  logic               ir_valid;
  logic               pc_update;
  logic [1:0]         pc_src;
  logic [PC_W-1:0]    branch_offset;
  logic [PC_W-1:0]    jump_target;
  logic [PC_W-1:0]    pc_out;
  logic [PC_W-1:0]    pc_plus2;
  logic               misaligned;
  logic [CNT_W-1:0]   instr_count;

  modport master (
    output fetch_req, imem_instr, pc_update, pc_src, branch_offset, jump_target,
    input  imem_pc, ir, ir_valid, pc_out, pc_plus2, misaligned, instr_count
  );

  modport slave (
    input  fetch_req, imem_instr, pc_update, pc_src, branch_offset, jump_target,
    output imem_pc, ir, ir_valid, pc_out, pc_plus2, misaligned, instr_count
  );
endinterface

// File: rtl/next_pc_calc.sv
// rtl/next_pc_calc.sv - next-PC select and adders with alignment fix-up
module next_pc_calc
  import cpu_pkg::*;
(
  input  logic [PC_W-1:0] pc,
  input  pc_src_t         pc_src,
  input  logic [PC_W-1:0] branch_offset,
  input  logic [PC_W-1:0] jump_target,
  output logic [PC_W-1:0] pc_plus2,
  output logic [PC_W-1:0] next_pc,
  output logic            misalign
);
  logic [PC_W-1:0] raw_pc;

  assign pc_plus2 = pc + PC_W'(INSTR_BYTES);

  always_comb begin
    raw_pc = pc;
    case (pc_src)
      PCSRC_SEQ:  raw_pc = pc_plus2;
      PCSRC_BR:   raw_pc = pc + branch_offset;
      PCSRC_JMP:  raw_pc = jump_target;
      PCSRC_HOLD: raw_pc = pc;
      default:    raw_pc = pc;
    endcase
  end

  // An odd target is forced even; the caller records the event as sticky.
  assign next_pc  = {raw_pc[PC_W-1:1], 1'b0};
  assign misalign = raw_pc[0];
endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, IR, retire counter and fetch FSM
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 16'h0000
) (
  input  logic      clk,
  input  logic      reset,
  fetch_unit_if.slave bus
);
  fetch_state_t       state_q, state_d;
  logic [PC_W-1:0]    pc_q;
  logic [INSTR_W-1:0] ir_q;
  logic [CNT_W-1:0]   count_q;
  logic               mis_q;
  logic [PC_W-1:0]    next_pc;
  logic [PC_W-1:0]    pc_plus2;
  logic               next_mis;
  logic               load_ir;
  logic               commit;

  next_pc_calc u_next_pc_calc (
    .pc            (pc_q),
    .pc_src        (pc_src_t'(bus.pc_src)),
    .branch_offset (bus.branch_offset),
    .jump_target   (bus.jump_target),
    .pc_plus2      (pc_plus2),
    .next_pc       (next_pc),
    .misalign      (next_mis)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load_ir = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE:  if (bus.fetch_req) state_d = FETCH;
      FETCH: begin
        load_ir = 1'b1;
        state_d = VALID;
      end
      VALID: if (bus.pc_update) begin
        commit  = 1'b1;
        state_d = bus.fetch_req ? FETCH : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      count_q <= '0;
      mis_q   <= 1'b0;
    end else begin
      if (load_ir) ir_q <= bus.imem_instr;
      if (commit) begin
        pc_q    <= next_pc;
        count_q <= count_q + CNT_W'(1);
        mis_q   <= mis_q | next_mis;
      end
    end
  end

  assign bus.imem_pc     = pc_q;
  assign bus.pc_out      = pc_q;
  assign bus.pc_plus2    = pc_plus2;
  assign bus.ir          = ir_q;
  assign bus.ir_valid    = (state_q == VALID);
  assign bus.misaligned  = mis_q;
  assign bus.instr_count = count_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit against a byte-addressed instruction memory
module tb_fetch_unit;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  logic [15:0] exp_pc;
  logic [15:0] exp_count;
  logic        exp_mis;
  logic [31:0] sb_q[$];

  fetch_unit_if fif ();

  fetch_unit #(.RESET_PC(16'h0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (fif.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    if (a == 16'h0000) return 8'h50;
    if (a == 16'h0001) return 8'h12;
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [15:0] imem_word(input logic [15:0] a);
    return {mem_byte(a + 16'd1), mem_byte(a)};
  endfunction

  assign fif.imem_instr = imem_word(fif.imem_pc);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_compare(input string tag);
    logic [31:0] e;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_ir"}, 32'(fif.ir), 32'(e[15:0]));
      check({tag, "_pc"}, 32'(fif.pc_out), 32'(e[31:16]));
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_pc"}, 32'(fif.pc_out), 32'(exp_pc));
    check({tag, "_cnt"}, 32'(fif.instr_count), 32'(exp_count));
    check({tag, "_mis"}, 32'(fif.misaligned), 32'(exp_mis));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    fif.fetch_req = 1'b0;
    fif.pc_update = 1'b0;
    fif.pc_src = 2'b00;
    fif.branch_offset = '0;
    fif.jump_target = '0;
    tick();
    reset = 1'b0;
    sb_q.delete();
    exp_pc = 16'h0000;
    exp_count = 16'h0000;
    exp_mis = 1'b0;
  endtask

  task automatic fetch_from_idle();
    fif.fetch_req = 1'b1;
    sb_q.push_back({exp_pc, imem_word(exp_pc)});
    tick();
    fif.fetch_req = 1'b0;
    check("fetch_cycle_valid", 32'(fif.ir_valid), 32'd0);
    tick();
    check("fetch_done_valid", 32'(fif.ir_valid), 32'd1);
    sb_compare("fetch");
  endtask

  task automatic commit(input logic [1:0] src, input logic [15:0] off,
                        input logic [15:0] tgt, input logic fr);
    logic [15:0] raw;
    case (src)
      2'b00:   raw = exp_pc + 16'd2;
      2'b01:   raw = exp_pc + off;
      2'b10:   raw = tgt;
      default: raw = exp_pc;
    endcase
    exp_mis   = exp_mis | raw[0];
    exp_pc    = raw & 16'hFFFE;
    exp_count = exp_count + 16'd1;
    fif.pc_update = 1'b1;
    fif.pc_src = src;
    fif.branch_offset = off;
    fif.jump_target = tgt;
    fif.fetch_req = fr;
    if (fr) sb_q.push_back({exp_pc, imem_word(exp_pc)});
    tick();
    fif.pc_update = 1'b0;
    fif.fetch_req = 1'b0;
    check("commit_valid_drop", 32'(fif.ir_valid), 32'd0);
    check_state("commit");
    if (fr) begin
      tick();
      check("b2b_valid", 32'(fif.ir_valid), 32'd1);
      sb_compare("b2b");
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pc"}, 32'(fif.pc_out), 32'h0000);
    check({tag, "_imem_pc"}, 32'(fif.imem_pc), 32'h0000);
    check({tag, "_ir"}, 32'(fif.ir), 32'h0000);
    check({tag, "_valid"}, 32'(fif.ir_valid), 32'd0);
    check({tag, "_mis"}, 32'(fif.misaligned), 32'd0);
    check({tag, "_cnt"}, 32'(fif.instr_count), 32'd0);
  endtask

  initial begin
    logic [15:0] held_ir;
    logic        fr;
    logic [1:0]  src;

    do_reset();
    check_reset_values("rst");

    // first fetch and sequential commit to IDLE
    fetch_from_idle();
    check("first_ir", 32'(fif.ir), 32'h1250);
    check("pc_plus2", 32'(fif.pc_plus2), 32'h0002);
    commit(2'b00, 16'h0, 16'h0, 1'b0);

    // back-to-back over PC 0,2,4,6
    do_reset();
    fetch_from_idle();
    commit(2'b00, 16'h0, 16'h0, 1'b1);
    commit(2'b00, 16'h0, 16'h0, 1'b1);
    commit(2'b00, 16'h0, 16'h0, 1'b1);
    commit(2'b00, 16'h0, 16'h0, 1'b0);
    check("b2b_end_pc", 32'(fif.pc_out), 32'h0008);
    check("b2b_end_cnt", 32'(fif.instr_count), 32'd4);

    // branch back, jump, wrap
    do_reset();
    fetch_from_idle();
    commit(2'b00, 16'h0, 16'h0, 1'b1);
    commit(2'b00, 16'h0, 16'h0, 1'b1);
    commit(2'b00, 16'h0, 16'h0, 1'b1);
    commit(2'b01, 16'hFFFA, 16'h0, 1'b1);
    check("branch_pc", 32'(fif.pc_out), 32'h0000);
    commit(2'b10, 16'h0, 16'h0040, 1'b1);
    check("jump_pc", 32'(fif.pc_out), 32'h0040);
    commit(2'b10, 16'h0, 16'hFFFE, 1'b1);
    check("wrap_plus2", 32'(fif.pc_plus2), 32'h0000);
    commit(2'b00, 16'h0, 16'h0, 1'b1);
    check("wrap_pc", 32'(fif.pc_out), 32'h0000);
    commit(2'b10, 16'h0, 16'h0002, 1'b1);
    commit(2'b01, 16'hFFFC, 16'h0, 1'b1);
    check("neg_branch_pc", 32'(fif.pc_out), 32'hFFFE);

    // misaligned jump is sticky
    commit(2'b10, 16'h0, 16'h0033, 1'b1);
    check("misjump_pc", 32'(fif.pc_out), 32'h0032);
    check("misjump_flag", 32'(fif.misaligned), 32'd1);
    commit(2'b10, 16'h0, 16'h0040, 1'b1);
    commit(2'b11, 16'h0, 16'h0, 1'b0);
    check("mis_sticky", 32'(fif.misaligned), 32'd1);
    check("hold_pc", 32'(fif.pc_out), 32'h0040);

    // pc_update ignored in IDLE and FETCH; fetch_req alone ignored in VALID
    do_reset();
    fif.pc_update = 1'b1;
    fif.pc_src = 2'b10;
    fif.jump_target = 16'h0100;
    tick();
    check("idle_upd_pc", 32'(fif.pc_out), 32'h0000);
    check("idle_upd_cnt", 32'(fif.instr_count), 32'd0);
    fif.fetch_req = 1'b1;
    sb_q.push_back({exp_pc, imem_word(exp_pc)});
    tick();
    fif.fetch_req = 1'b0;
    check("fetch_st_valid", 32'(fif.ir_valid), 32'd0);
    tick();
    fif.pc_update = 1'b0;
    check("fetch_upd_valid", 32'(fif.ir_valid), 32'd1);
    check_state("fetch_upd");
    sb_compare("ign");
    held_ir = fif.ir;
    fif.fetch_req = 1'b1;
    tick();
    tick();
    fif.fetch_req = 1'b0;
    check("valid_freq_valid", 32'(fif.ir_valid), 32'd1);
    check("valid_freq_ir", 32'(fif.ir), 32'(held_ir));
    check_state("valid_freq");

    // reset mid-FETCH
    commit(2'b10, 16'h0, 16'h0011, 1'b1);
    commit(2'b00, 16'h0, 16'h0, 1'b0);
    fif.fetch_req = 1'b1;
    tick();
    check("pre_rst_fetch", 32'(fif.ir_valid), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    fif.fetch_req = 1'b0;
    sb_q.delete();
    check_reset_values("rst_fetch");
    tick();
    check("rst_fetch_idle", 32'(fif.ir_valid), 32'd0);

    // reset mid-VALID, with competing inputs
    exp_pc = 16'h0000; exp_count = 16'h0000; exp_mis = 1'b0;
    fetch_from_idle();
    commit(2'b10, 16'h0, 16'h0021, 1'b1);
    reset = 1'b1;
    fif.pc_update = 1'b1;
    fif.fetch_req = 1'b1;
    fif.pc_src = 2'b00;
    tick();
    reset = 1'b0;
    fif.pc_update = 1'b0;
    fif.fetch_req = 1'b0;
    sb_q.delete();
    check_reset_values("rst_valid");
    tick();
    check("rst_valid_idle", 32'(fif.ir_valid), 32'd0);

    // random commit mix
    exp_pc = 16'h0000; exp_count = 16'h0000; exp_mis = 1'b0;
    fetch_from_idle();
    for (int i = 0; i < 24; i++) begin
      src = 2'($urandom_range(0, 3));
      fr  = 1'($urandom_range(0, 1));
      commit(src, 16'($urandom), 16'($urandom), fr);
      if (!fr) fetch_from_idle();
    end
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
